// File: rtl/gain_oot_core.sv
// gain_oot user core: CtrlPort register file, two-stage complex-gain datapath with
// round-half-up and saturation, and a combinational context pass-through.
`timescale 1ns/1ps
module gain_oot_core #(
    parameter int unsigned CHDR_W     = 64,
    parameter logic [19:0] GAIN_ADDR  = 20'h0,
    parameter int unsigned GAIN_FRAC  = 8,
    parameter logic [15:0] GAIN_RESET = 16'h0100
) (
    input  logic              axis_data_clk,
    input  logic              axis_data_rst_n,
    // CtrlPort slave
    input  logic              s_ctrlport_req_wr,
    input  logic              s_ctrlport_req_rd,
    input  logic [19:0]       s_ctrlport_req_addr,
    input  logic [31:0]       s_ctrlport_req_data,
    output logic              s_ctrlport_resp_ack,
    output logic [31:0]       s_ctrlport_resp_data,
    // Input payload / context
    input  logic [31:0]       s_in_payload_tdata,
    input  logic              s_in_payload_tkeep,
    input  logic              s_in_payload_tlast,
    input  logic              s_in_payload_tvalid,
    output logic              s_in_payload_tready,
    input  logic [CHDR_W-1:0] s_in_context_tdata,
    input  logic [3:0]        s_in_context_tuser,
    input  logic              s_in_context_tlast,
    input  logic              s_in_context_tvalid,
    output logic              s_in_context_tready,
    // Output payload / context
    output logic [31:0]       m_out_payload_tdata,
    output logic              m_out_payload_tkeep,
    output logic              m_out_payload_tlast,
    output logic              m_out_payload_tvalid,
    input  logic              m_out_payload_tready,
    output logic [CHDR_W-1:0] m_out_context_tdata,
    output logic [3:0]        m_out_context_tuser,
    output logic              m_out_context_tlast,
    output logic              m_out_context_tvalid,
    input  logic              m_out_context_tready
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 32;
    localparam int unsigned RW = PW + 1;
    localparam logic [19:0] SAT_ADDR = GAIN_ADDR + 20'd4;
    localparam logic signed [RW-1:0] RND = 33'sd1 <<< (GAIN_FRAC - 1);
    localparam logic signed [RW-1:0] MAX_S = 33'sd32767;
    localparam logic signed [RW-1:0] MIN_S = -33'sd32768;

    logic                 run;
    logic                 sop;
    logic                 v1;
    logic                 v2;
    logic                 en;
    logic                 hs;
    logic signed [DW-1:0] gain_reg;
    logic signed [DW-1:0] gain_active;
    logic signed [DW-1:0] gain_use;
    logic signed [DW-1:0] in_i;
    logic signed [DW-1:0] in_q;
    logic signed [PW-1:0] p1_i;
    logic signed [PW-1:0] p1_q;
    logic                 keep1;
    logic                 last1;
    logic signed [RW-1:0] r_i;
    logic signed [RW-1:0] r_q;
    logic [DW-1:0]        sat_i;
    logic [DW-1:0]        sat_q;
    logic                 clip_i;
    logic                 clip_q;
    logic [31:0]          sat_count;
    logic [31:0]          rdata_c;
    logic                 gain_wr;
    logic                 sat_wr;
    logic                 unused_data_hi;

    assign unused_data_hi = ^s_ctrlport_req_data[31:16];

    // Stall-all pipeline control
    assign en                  = !v2 || m_out_payload_tready;
    assign s_in_payload_tready = en && run;
    assign hs                  = s_in_payload_tready && s_in_payload_tvalid;

    // First item of a packet picks up the latest programmed gain
    assign gain_use = sop ? gain_reg : gain_active;
    assign in_i     = s_in_payload_tdata[31:16];
    assign in_q     = s_in_payload_tdata[15:0];

    assign gain_wr = s_ctrlport_req_wr && (s_ctrlport_req_addr == GAIN_ADDR);
    assign sat_wr  = s_ctrlport_req_wr && (s_ctrlport_req_addr == SAT_ADDR);

    // Context is forwarded untouched
    assign m_out_context_tdata  = s_in_context_tdata;
    assign m_out_context_tuser  = s_in_context_tuser;
    assign m_out_context_tlast  = s_in_context_tlast;
    assign m_out_context_tvalid = s_in_context_tvalid;
    assign s_in_context_tready  = m_out_context_tready && run;

    assign m_out_payload_tvalid = v2;

    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Packet-boundary gain latch
    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            sop         <= 1'b1;
            gain_active <= GAIN_RESET;
        end else if (hs) begin
            if (sop) begin
                gain_active <= gain_reg;
            end
            sop <= s_in_payload_tlast;
        end
    end

    // Stage 1: products
    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            p1_i  <= '0;
            p1_q  <= '0;
            keep1 <= 1'b0;
            last1 <= 1'b0;
            v1    <= 1'b0;
        end else if (en) begin
            p1_i  <= PW'(in_i) * PW'(gain_use);
            p1_q  <= PW'(in_q) * PW'(gain_use);
            keep1 <= s_in_payload_tkeep;
            last1 <= s_in_payload_tlast;
            v1    <= hs;
        end
    end

    // Round half up, then clip to sc16
    always_comb begin
        r_i    = ($signed({p1_i[PW-1], p1_i}) + RND) >>> GAIN_FRAC;
        r_q    = ($signed({p1_q[PW-1], p1_q}) + RND) >>> GAIN_FRAC;
        clip_i = (r_i > MAX_S) || (r_i < MIN_S);
        clip_q = (r_q > MAX_S) || (r_q < MIN_S);
        sat_i  = r_i[DW-1:0];
        sat_q  = r_q[DW-1:0];
        if (r_i > MAX_S) sat_i = 16'h7fff;
        if (r_i < MIN_S) sat_i = 16'h8000;
        if (r_q > MAX_S) sat_q = 16'h7fff;
        if (r_q < MIN_S) sat_q = 16'h8000;
    end

    // Stage 2: output registers
    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            m_out_payload_tdata <= '0;
            m_out_payload_tkeep <= 1'b0;
            m_out_payload_tlast <= 1'b0;
            v2                  <= 1'b0;
        end else if (en) begin
            m_out_payload_tdata <= {sat_i, sat_q};
            m_out_payload_tkeep <= keep1;
            m_out_payload_tlast <= last1;
            v2                  <= v1;
        end
    end

    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            sat_count <= '0;
        end else if (sat_wr) begin
            sat_count <= '0;
        end else if (en && v1 && (clip_i || clip_q) && (sat_count != 32'hffff_ffff)) begin
            sat_count <= sat_count + 32'd1;
        end
    end

    always_comb begin
        rdata_c = '0;
        if (s_ctrlport_req_addr == GAIN_ADDR) begin
            rdata_c = {16'h0, gain_reg};
        end else if (s_ctrlport_req_addr == SAT_ADDR) begin
            rdata_c = sat_count;
        end
    end

    // Register file and single-cycle response
    always_ff @(posedge axis_data_clk or negedge axis_data_rst_n) begin
        if (!axis_data_rst_n) begin
            gain_reg             <= GAIN_RESET;
            s_ctrlport_resp_ack  <= 1'b0;
            s_ctrlport_resp_data <= '0;
        end else begin
            if (gain_wr) begin
                gain_reg <= s_ctrlport_req_data[15:0];
            end
            s_ctrlport_resp_ack  <= s_ctrlport_req_wr || s_ctrlport_req_rd;
            s_ctrlport_resp_data <= s_ctrlport_req_rd ? rdata_c : 32'h0;
        end
    end

endmodule

// File: tb/tb_gain_oot_core.sv
// Scoreboard bench for gain_oot_core: reference model queue filled at input accept,
// drained by an output monitor.
`timescale 1ns/1ps
module tb_gain_oot_core;

    localparam int unsigned CHDR_W = 64;
    localparam int unsigned F      = 8;
    localparam logic [19:0] A_GAIN = 20'h0;
    localparam logic [19:0] A_SAT  = 20'h4;

    logic              axis_data_clk = 1'b0;
    logic              axis_data_rst_n = 1'b0;
    logic              s_ctrlport_req_wr = 1'b0;
    logic              s_ctrlport_req_rd = 1'b0;
    logic [19:0]       s_ctrlport_req_addr = '0;
    logic [31:0]       s_ctrlport_req_data = '0;
    logic              s_ctrlport_resp_ack;
    logic [31:0]       s_ctrlport_resp_data;
    logic [31:0]       s_in_payload_tdata = '0;
    logic              s_in_payload_tkeep = 1'b0;
    logic              s_in_payload_tlast = 1'b0;
    logic              s_in_payload_tvalid = 1'b0;
    logic              s_in_payload_tready;
    logic [CHDR_W-1:0] s_in_context_tdata = '0;
    logic [3:0]        s_in_context_tuser = '0;
    logic              s_in_context_tlast = 1'b0;
    logic              s_in_context_tvalid = 1'b0;
    logic              s_in_context_tready;
    logic [31:0]       m_out_payload_tdata;
    logic              m_out_payload_tkeep;
    logic              m_out_payload_tlast;
    logic              m_out_payload_tvalid;
    logic              m_out_payload_tready = 1'b1;
    logic [CHDR_W-1:0] m_out_context_tdata;
    logic [3:0]        m_out_context_tuser;
    logic              m_out_context_tlast;
    logic              m_out_context_tvalid;
    logic              m_out_context_tready = 1'b1;

    gain_oot_core #(.CHDR_W(CHDR_W), .GAIN_ADDR(A_GAIN), .GAIN_FRAC(F), .GAIN_RESET(16'h0100)) dut (
        .axis_data_clk(axis_data_clk), .axis_data_rst_n(axis_data_rst_n),
        .s_ctrlport_req_wr(s_ctrlport_req_wr), .s_ctrlport_req_rd(s_ctrlport_req_rd),
        .s_ctrlport_req_addr(s_ctrlport_req_addr), .s_ctrlport_req_data(s_ctrlport_req_data),
        .s_ctrlport_resp_ack(s_ctrlport_resp_ack), .s_ctrlport_resp_data(s_ctrlport_resp_data),
        .s_in_payload_tdata(s_in_payload_tdata), .s_in_payload_tkeep(s_in_payload_tkeep),
        .s_in_payload_tlast(s_in_payload_tlast), .s_in_payload_tvalid(s_in_payload_tvalid),
        .s_in_payload_tready(s_in_payload_tready),
        .s_in_context_tdata(s_in_context_tdata), .s_in_context_tuser(s_in_context_tuser),
        .s_in_context_tlast(s_in_context_tlast), .s_in_context_tvalid(s_in_context_tvalid),
        .s_in_context_tready(s_in_context_tready),
        .m_out_payload_tdata(m_out_payload_tdata), .m_out_payload_tkeep(m_out_payload_tkeep),
        .m_out_payload_tlast(m_out_payload_tlast), .m_out_payload_tvalid(m_out_payload_tvalid),
        .m_out_payload_tready(m_out_payload_tready),
        .m_out_context_tdata(m_out_context_tdata), .m_out_context_tuser(m_out_context_tuser),
        .m_out_context_tlast(m_out_context_tlast), .m_out_context_tvalid(m_out_context_tvalid),
        .m_out_context_tready(m_out_context_tready)
    );

    always #5 axis_data_clk = ~axis_data_clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        keep;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          lat_mode = 0;
    bit          rand_rdy = 0;
    logic        hold_rdy = 1'b1;
    logic [15:0] m_gain_reg = 16'h0100;
    logic [15:0] m_gain_act = 16'h0100;
    bit          m_sop = 1;
    int          m_sat = 0;

    always @(posedge axis_data_clk) cyc <= cyc + 1;

    // Output back-pressure, changed just after each rising edge
    initial begin
        forever begin
            @(posedge axis_data_clk);
            #1;
            m_out_payload_tready = rand_rdy ? 1'($urandom % 2) : hold_rdy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Real-valued gain applied with floor((x*g)/2^F + 1/2) and clipped to sc16
    function automatic logic [15:0] ref_comp(input logic [15:0] x, input logic [15:0] g, output bit clip);
        longint p, t, r, den;
        den = longint'(1) << F;
        p = longint'($signed(x)) * longint'($signed(g));
        t = p + den / 2;
        if (t >= 0) r = t / den;
        else r = -((-t + den - 1) / den);
        clip = 0;
        if (r > 32767) begin r = 32767; clip = 1; end
        else if (r < -32768) begin r = -32768; clip = 1; end
        return r[15:0];
    endfunction

    task automatic model_accept(input logic [15:0] i, input logic [15:0] qv, input logic last);
        exp_t e;
        bit ci, cq;
        logic [15:0] oi, oq;
        if (m_sop) m_gain_act = m_gain_reg;
        m_sop = last;
        oi = ref_comp(i, m_gain_act, ci);
        oq = ref_comp(qv, m_gain_act, cq);
        if (ci || cq) m_sat++;
        e.data = {oi, oq};
        e.last = last;
        e.keep = 1'b1;
        e.acc  = cyc;
        q.push_back(e);
    endtask

    task automatic model_reset();
        q.delete();
        m_gain_reg = 16'h0100;
        m_gain_act = 16'h0100;
        m_sop = 1;
        m_sat = 0;
    endtask

    // Called at a falling edge; leaves tvalid high for back-to-back streaming
    task automatic send_item(input logic [15:0] i, input logic [15:0] qv, input logic last);
        int guard = 0;
        s_in_payload_tdata  = {i, qv};
        s_in_payload_tlast  = last;
        s_in_payload_tkeep  = 1'b1;
        s_in_payload_tvalid = 1'b1;
        while (!s_in_payload_tready && guard < 1000) begin
            @(negedge axis_data_clk);
            guard++;
        end
        if (!s_in_payload_tready) begin
            chk("in_handshake_timeout", 64'(s_in_payload_tready), 64'd1);
            s_in_payload_tvalid = 1'b0;
            return;
        end
        model_accept(i, qv, last);
        @(negedge axis_data_clk);
    endtask

    task automatic ctrl_write(input logic [19:0] addr, input logic [31:0] data);
        s_in_payload_tvalid = 1'b0;
        s_ctrlport_req_wr   = 1'b1;
        s_ctrlport_req_addr = addr;
        s_ctrlport_req_data = data;
        @(negedge axis_data_clk);
        s_ctrlport_req_wr = 1'b0;
        if (addr == A_GAIN) m_gain_reg = data[15:0];
        if (addr == A_SAT) m_sat = 0;
        chk("wr_ack", 64'(s_ctrlport_resp_ack), 64'd1);
        chk("wr_resp_data", 64'(s_ctrlport_resp_data), 64'd0);
        @(negedge axis_data_clk);
        chk("wr_ack_clear", 64'(s_ctrlport_resp_ack), 64'd0);
    endtask

    task automatic ctrl_read(input logic [19:0] addr, output logic [31:0] data);
        s_in_payload_tvalid = 1'b0;
        s_ctrlport_req_rd   = 1'b1;
        s_ctrlport_req_addr = addr;
        @(negedge axis_data_clk);
        s_ctrlport_req_rd = 1'b0;
        chk("rd_ack", 64'(s_ctrlport_resp_ack), 64'd1);
        data = s_ctrlport_resp_data;
        @(negedge axis_data_clk);
        chk("rd_ack_clear", 64'(s_ctrlport_resp_ack), 64'd0);
        chk("rd_data_idle_zero", 64'(s_ctrlport_resp_data), 64'd0);
    endtask

    task automatic drain();
        int g = 0;
        s_in_payload_tvalid = 1'b0;
        while (q.size() != 0 && g < 500) begin
            @(negedge axis_data_clk);
            g++;
        end
        chk("drain_pending", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    // Output monitor: pops expectations on each output handshake, checks stall stability
    logic [32:0] prev_out;
    logic        prev_stall = 1'b0;
    always @(negedge axis_data_clk) begin
        exp_t e;
        if (!axis_data_rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_held", 64'(m_out_payload_tvalid), 64'd1);
                chk("stall_data_held", 64'({m_out_payload_tlast, m_out_payload_tdata}), 64'(prev_out));
            end
            if (m_out_payload_tvalid && m_out_payload_tready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(q.size()), 64'd1);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 64'(m_out_payload_tdata), 64'(e.data));
                    chk("out_last", 64'(m_out_payload_tlast), 64'(e.last));
                    chk("out_keep", 64'(m_out_payload_tkeep), 64'(e.keep));
                    if (lat_mode) chk("latency", 64'(cyc - e.acc), 64'd2);
                end
            end
            prev_stall <= m_out_payload_tvalid && !m_out_payload_tready;
            prev_out   <= {m_out_payload_tlast, m_out_payload_tdata};
        end
    end

    initial begin
        logic [31:0] rd;
        logic [63:0] ctx;
        int items;
        int len;

        // Reset state
        repeat (3) @(negedge axis_data_clk);
        chk("rst_in_tready", 64'(s_in_payload_tready), 64'd0);
        chk("rst_ctx_tready", 64'(s_in_context_tready), 64'd0);
        chk("rst_out_tvalid", 64'(m_out_payload_tvalid), 64'd0);
        chk("rst_out_tdata", 64'(m_out_payload_tdata), 64'd0);
        chk("rst_ack", 64'(s_ctrlport_resp_ack), 64'd0);
        axis_data_rst_n = 1'b1;
        #1;
        chk("release_in_tready", 64'(s_in_payload_tready), 64'd0);
        @(negedge axis_data_clk);
        chk("run_in_tready", 64'(s_in_payload_tready), 64'd1);

        ctrl_read(A_GAIN, rd);  chk("gain_reset", 64'(rd), 64'h100);
        ctrl_read(A_SAT, rd);   chk("sat_reset", 64'(rd), 64'h0);
        ctrl_write(20'h40, 32'hdead_beef);
        ctrl_read(20'h40, rd);  chk("unmapped_rd", 64'(rd), 64'h0);
        ctrl_write(A_GAIN, 32'hffff_0100);
        ctrl_read(A_GAIN, rd);  chk("gain_upper_ignored", 64'(rd), 64'h100);

        // Context pass-through
        ctx = {$urandom, $urandom};
        s_in_context_tdata = ctx; s_in_context_tuser = 4'ha;
        s_in_context_tlast = 1'b1; s_in_context_tvalid = 1'b1;
        #1;
        chk("ctx_tdata", m_out_context_tdata, ctx);
        chk("ctx_tuser", 64'(m_out_context_tuser), 64'ha);
        chk("ctx_tvalid", 64'(m_out_context_tvalid), 64'd1);
        chk("ctx_tready", 64'(s_in_context_tready), 64'd1);
        m_out_context_tready = 1'b0;
        #1;
        chk("ctx_tready_bp", 64'(s_in_context_tready), 64'd0);
        m_out_context_tready = 1'b1; s_in_context_tvalid = 1'b0;
        @(negedge axis_data_clk);

        // Unity ramp, latency 2
        lat_mode = 1;
        for (int k = 1; k <= 8; k++) send_item(16'(k), 16'(k), k == 8);
        drain();
        lat_mode = 0;
        ctrl_read(A_SAT, rd);   chk("sat_unity", 64'(rd), 64'h0);

        // Fractional gains and rounding
        ctrl_write(A_GAIN, 32'h0180);
        send_item(16'd1000, -16'sd1000, 1'b1);
        drain();
        ctrl_write(A_GAIN, 32'h0080);
        send_item(16'd3, -16'sd3, 1'b1);
        drain();

        // Saturation and counter clear
        ctrl_write(A_GAIN, 32'h0200);
        send_item(16'd30000, -16'sd30000, 1'b1);
        drain();
        ctrl_read(A_SAT, rd);   chk("sat_one", 64'(rd), 64'(m_sat));
        ctrl_write(A_SAT, 32'h1);
        ctrl_read(A_SAT, rd);   chk("sat_cleared", 64'(rd), 64'h0);

        // Mid-packet gain write takes effect on the next packet
        ctrl_write(A_GAIN, 32'h0100);
        for (int k = 0; k < 3; k++) send_item(16'(100 + k), 16'(-200 - k), 1'b0);
        ctrl_write(A_GAIN, 32'h0200);
        ctrl_read(A_GAIN, rd);  chk("gain_readback", 64'(rd), 64'h200);
        for (int k = 3; k < 6; k++) send_item(16'(100 + k), 16'(-200 - k), k == 5);
        for (int k = 0; k < 4; k++) send_item(16'(50 + k), 16'(60 + k), k == 3);
        drain();

        // GAIN write in the same cycle as a start-of-packet accept
        ctrl_write(A_GAIN, 32'h0100);
        chk("sop_wr_ready", 64'(s_in_payload_tready), 64'd1);
        s_ctrlport_req_wr = 1'b1; s_ctrlport_req_addr = A_GAIN; s_ctrlport_req_data = 32'h0300;
        s_in_payload_tdata = {16'd100, 16'hff9c}; s_in_payload_tlast = 1'b0;
        s_in_payload_tkeep = 1'b1; s_in_payload_tvalid = 1'b1;
        model_accept(16'd100, 16'hff9c, 1'b0);
        m_gain_reg = 16'h0300;
        @(negedge axis_data_clk);
        s_ctrlport_req_wr = 1'b0;
        chk("sop_wr_ack", 64'(s_ctrlport_resp_ack), 64'd1);
        send_item(16'd200, 16'd7, 1'b1);
        send_item(16'd11, 16'hfff5, 1'b1);
        drain();

        // Random stream under random back-pressure
        rand_rdy = 1;
        items = 0;
        while (items < 1000) begin
            if ($urandom % 6 == 0) ctrl_write(A_GAIN, 32'($urandom % 65536));
            len = 1 + int'($urandom % 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom % 4 == 0) begin
                    s_in_payload_tvalid = 1'b0;
                    @(negedge axis_data_clk);
                end
                send_item(16'($urandom), 16'($urandom), k == len - 1);
                items++;
            end
        end
        s_in_payload_tvalid = 1'b0;
        rand_rdy = 0;
        hold_rdy = 1'b1;
        drain();
        ctrl_read(A_SAT, rd);   chk("sat_random", 64'(rd), 64'(m_sat));

        // Reset with two items in flight
        ctrl_write(A_GAIN, 32'h0300);
        hold_rdy = 1'b0;
        repeat (2) @(negedge axis_data_clk);
        send_item(16'd1, 16'd2, 1'b0);
        send_item(16'd3, 16'd4, 1'b1);
        s_in_payload_tvalid = 1'b0;
        chk("pre_reset_valid", 64'(m_out_payload_tvalid), 64'd1);
        axis_data_rst_n = 1'b0;
        #1;
        chk("reset_tvalid_now", 64'(m_out_payload_tvalid), 64'd0);
        chk("reset_in_tready", 64'(s_in_payload_tready), 64'd0);
        model_reset();
        hold_rdy = 1'b1;
        repeat (3) @(negedge axis_data_clk);
        chk("reset_ack", 64'(s_ctrlport_resp_ack), 64'd0);
        axis_data_rst_n = 1'b1;
        #1;
        chk("rerelease_in_tready", 64'(s_in_payload_tready), 64'd0);
        chk("rerelease_ctx_tready", 64'(s_in_context_tready), 64'd0);
        @(negedge axis_data_clk);
        chk("rerun_in_tready", 64'(s_in_payload_tready), 64'd1);
        chk("rerun_ctx_tready", 64'(s_in_context_tready), 64'd1);
        chk("rerun_tvalid", 64'(m_out_payload_tvalid), 64'd0);
        ctrl_read(A_GAIN, rd);  chk("gain_after_reset", 64'(rd), 64'h100);
        ctrl_read(A_SAT, rd);   chk("sat_after_reset", 64'(rd), 64'h0);
        send_item(16'd1234, 16'hedcc, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
